// File: rtl/net2axis_arbiter_if.sv
// ---------------------------------------------------------------------------
// net2axis_arbiter_if
//   AXI-Stream bundle used on both sides of net2axis_arbiter. C_LANES streams
//   are packed side by side: lane i occupies TDATA[i*W +: W],
//   TKEEP[i*W/8 +: W/8] and bit i of TVALID/TLAST/TREADY.
//   The arbiter's input side uses C_LANES = C_NUM_SLAVES, its output side 1.
// Modports
//   master : drives TVALID/TDATA/TKEEP/TLAST, receives TREADY
//   slave  : receives TVALID/TDATA/TKEEP/TLAST, drives TREADY
// ---------------------------------------------------------------------------
interface net2axis_arbiter_if #(
  parameter int C_TDATA_WIDTH = 32,
  parameter int C_LANES       = 1
);
  logic [C_LANES-1:0]                 TVALID;
  logic [C_LANES*C_TDATA_WIDTH-1:0]   TDATA;
  logic [C_LANES*C_TDATA_WIDTH/8-1:0] TKEEP;
  logic [C_LANES-1:0]                 TLAST;
  logic [C_LANES-1:0]                 TREADY;

  modport master (output TVALID, TDATA, TKEEP, TLAST, input TREADY);
  modport slave  (input TVALID, TDATA, TKEEP, TLAST, output TREADY);
endinterface

// File: rtl/net2axis_arbiter.sv
// ---------------------------------------------------------------------------
// net2axis_arbiter
//   Packet-level round-robin arbiter: C_NUM_SLAVES AXI-Stream inputs share one
//   AXI-Stream output. A grant is held from the first beat through TLAST, so
//   packets never interleave. One idle (arbitration) cycle separates packets.
// Ports
//   ACLK       clock, rising edge
//   ARESET     asynchronous, active-high reset
//   S_AXIS     input streams (slave modport, C_NUM_SLAVES lanes)
//   M_AXIS     output stream (master modport, 1 lane)
//   GRANT      one-hot current grant, 0 while idle
//   BUSY       1 while a packet is being forwarded
//   PKT_COUNT  (only with NET2AXIS_ARB_PKTCNT_EN) per-input 32-bit packet
//              counters, input i at [i*32 +: 32]
// Build option
//   `define NET2AXIS_ARB_PKTCNT_EN to add PKT_COUNT and its counters.
// ---------------------------------------------------------------------------
module net2axis_arbiter #(
  parameter int C_TDATA_WIDTH = 32,
  parameter int C_NUM_SLAVES  = 2
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  net2axis_arbiter_if.slave       S_AXIS,
  net2axis_arbiter_if.master      M_AXIS,
  output logic [C_NUM_SLAVES-1:0] GRANT,
  output logic                    BUSY
`ifdef NET2AXIS_ARB_PKTCNT_EN
  ,
  output logic [C_NUM_SLAVES*32-1:0] PKT_COUNT
`endif
);

  localparam int W     = C_TDATA_WIDTH;
  localparam int KW    = C_TDATA_WIDTH / 8;
  localparam int N     = C_NUM_SLAVES;
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FWD  = 1'b1;

  localparam logic [N-1:0]     ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] PTR_RST  = SEL_W'(N - 1);

  logic [0:0]       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  // ptr_q is both the mux select while forwarding and the last-grant pointer
  // that the next arbitration round starts after.
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             busy;
  logic             found;
  logic [SEL_W-1:0] pick;
  logic             xfer_last;

  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return SEL_W'(s);
  endfunction

  assign busy = (state_q == ST_FWD);

  // Round-robin search starting just after the last granted input.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 1; k <= N; k++) begin
      if (!found && S_AXIS.TVALID[wrap_add(ptr_q, k)]) begin
        found = 1'b1;
        pick  = wrap_add(ptr_q, k);
      end
    end
  end

  // Output mux. Data/keep are forced to 0 while idle so the stale select never
  // exposes a non-granted input; only the granted lane ever reaches M_AXIS.
  assign M_AXIS.TVALID = busy & S_AXIS.TVALID[ptr_q];
  assign M_AXIS.TLAST  = busy & S_AXIS.TLAST[ptr_q];
  assign M_AXIS.TDATA  = busy ? S_AXIS.TDATA[int'(ptr_q)*W +: W]   : '0;
  assign M_AXIS.TKEEP  = busy ? S_AXIS.TKEEP[int'(ptr_q)*KW +: KW] : '0;

  // grant_q is zero while idle, so no input is ever acknowledged outside FWD.
  assign S_AXIS.TREADY = grant_q & {N{M_AXIS.TREADY}};

  assign xfer_last = M_AXIS.TVALID & M_AXIS.TREADY & M_AXIS.TLAST;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = ONE_HOT0 << pick;
          ptr_d   = pick;
          state_d = ST_FWD;
        end
      end
      ST_FWD: begin
        if (xfer_last) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign GRANT = grant_q;
  assign BUSY  = busy;

`ifdef NET2AXIS_ARB_PKTCNT_EN
  // One free-running 32-bit counter per input; natural overflow wraps to 0.
  for (genvar i = 0; i < N; i++) begin : g_pktcnt
    logic [31:0] cnt_q;
    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        cnt_q <= '0;
      end else if (xfer_last && (ptr_q == SEL_W'(i))) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign PKT_COUNT[i*32 +: 32] = cnt_q;
  end
`endif

endmodule
